// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional zero fill of unused memory is enabled by defining IMEM_ZERO_FILL_EN.
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned LANE_W         = 2;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StFlush = 2'd1,
        StFill  = 2'd2,
        StRun   = 2'd3
    } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words and emits a one-cycle word_valid
// pulse with the completed (zero-padded if cut short) word on the cycle after the final byte.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fire,
    input  logic [7:0]        data,
    input  logic              last,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    output logic              word_short
);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;
    logic              short_q, short_d;
    logic [WORD_W-1:0] merged;

    always_comb begin
        // acc_q is cleared after every word, so unfilled upper lanes read as zero
        merged  = acc_q | ({{(WORD_W - 8){1'b0}}, data} << {lane_q, 3'b000});
        lane_d  = lane_q;
        acc_d   = acc_q;
        word_d  = word_q;
        valid_d = 1'b0;
        short_d = 1'b0;
        if (fire) begin
            if (last || (lane_q == LAST_LANE)) begin
                word_d  = merged;
                valid_d = 1'b1;
                short_d = last && (lane_q != LAST_LANE);
                lane_d  = '0;
                acc_d   = '0;
            end else begin
                acc_d  = merged;
                lane_d = lane_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q  <= '0;
            acc_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            short_q <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            acc_q   <= acc_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            short_q <= short_d;
        end
    end

    assign word_valid = valid_q;
    assign word_data  = word_q;
    assign word_short = short_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: streams bytes into sequential words, then releases the CPU.
// Define IMEM_ZERO_FILL_EN to zero the remaining memory words before releasing the CPU.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    input  logic              byte_last_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              cpu_start_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic              armed_q;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;

    logic              fire;
    logic              full;
    logic              word_valid;
    logic              word_short;
    logic [WORD_W-1:0] word_data;

    // armed_q keeps ready low for the first cycle after reset release
    assign byte_ready_o = armed_q && (state_q == StLoad);
    assign fire         = byte_valid_i && byte_ready_o;
    assign full         = (count_q == FULL_COUNT);

    byte_packer u_byte_packer (
        .clk        (clk_i),
        .rst_n      (start_i),
        .fire       (fire),
        .data       (byte_data_i),
        .last       (byte_last_i),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_short (word_short)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        err_d       = err_q;
        mem_we_o    = 1'b0;
        mem_addr_o  = ptr_q;
        mem_wdata_o = word_data;

        // Words past the end of memory are dropped; the count saturates at DEPTH
        if (word_valid) begin
            if (full) begin
                err_d = 1'b1;
            end else begin
                mem_we_o = 1'b1;
                ptr_d    = ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end
        end
        if (word_short) begin
            err_d = 1'b1;
        end

        case (state_q)
            StLoad: begin
                if (fire && byte_last_i) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
`ifdef IMEM_ZERO_FILL_EN
                state_d = (count_d == FULL_COUNT) ? StRun : StFill;
`else
                state_d = StRun;
`endif
            end
            StFill: begin
`ifdef IMEM_ZERO_FILL_EN
                mem_we_o    = 1'b1;
                mem_wdata_o = '0;
                ptr_d       = ptr_q + 1'b1;
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = StRun;
                end
`else
                // Unreachable without the fill feature
                state_d = StRun;
`endif
            end
            StRun: begin
                state_d = StRun;
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q <= StLoad;
            armed_q <= 1'b0;
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign cpu_start_o  = (state_q == StRun);
    assign done_o       = (state_q == StRun);
    assign word_count_o = count_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; expectations follow IMEM_ZERO_FILL_EN.
module tb_imem_loader;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

`ifdef IMEM_ZERO_FILL_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_last = 1'b0;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_start;
    logic [ADDR_W:0]   word_count;
    logic              done;
    logic              err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  log_addr [0:2047];
    logic [31:0] log_data [0:2047];
    int          wr_n = 0;
    int          base = 0;

    imem_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_i        (clk),
        .start_i      (start),
        .byte_valid_i (byte_valid),
        .byte_data_i  (byte_data),
        .byte_last_i  (byte_last),
        .byte_ready_o (byte_ready),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .cpu_start_o  (cpu_start),
        .word_count_o (word_count),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled mid-cycle so each one-cycle strobe is seen once
    always @(negedge clk) begin
        if (mem_we && wr_n < 2048) begin
            log_addr[wr_n] = mem_addr;
            log_data[wr_n] = mem_wdata;
            wr_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        start      = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
    endtask

    // Returns at the negedge following the transfer edge
    task automatic send(input logic [7:0] d, input logic l);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = l;
        while (!byte_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("ready_timeout", {31'b0, byte_ready}, 32'd1);
        else @(negedge clk);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic wait_run();
        int t = 0;
        while (!cpu_start && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("run_reached", {31'b0, cpu_start}, 32'd1);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b3 [0:7];
        int         t;

        // Reset values
        #12;
        chk("rst_ready", {31'b0, byte_ready}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", {24'b0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_start", {31'b0, cpu_start}, 32'd0);
        chk("rst_count", {23'b0, word_count}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        start = 1'b1;
        #1;
        chk("ready_held_first_cycle", {31'b0, byte_ready}, 32'd0);
        @(negedge clk);
        chk("ready_after_reset", {31'b0, byte_ready}, 32'd1);

        // Aligned two-word load
        base = wr_n;
        send(8'h13, 1'b0); send(8'h05, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        send(8'h93, 1'b0); send(8'h05, 1'b0); send(8'h10, 1'b0); send(8'h00, 1'b1);
        chk("al_flush_we", {31'b0, mem_we}, 32'd1);
        chk("al_flush_addr", {24'b0, mem_addr}, 32'd1);
        chk("al_flush_wdata", mem_wdata, 32'h00100593);
        chk("al_flush_cpu_start", {31'b0, cpu_start}, 32'd0);
        chk("al_flush_ready", {31'b0, byte_ready}, 32'd0);
`ifndef IMEM_ZERO_FILL_EN
        @(negedge clk);
        chk("al_cpu_start_next", {31'b0, cpu_start}, 32'd1);
        #1;
`else
        wait_run();
`endif
        chk("al_done", {31'b0, done}, 32'd1);
        chk("al_count", {23'b0, word_count}, 32'd2);
        chk("al_err", {31'b0, err}, 32'd0);
        chk("al_ready_run", {31'b0, byte_ready}, 32'd0);
        chk("al_nwrites", wr_n - base, FILL ? DEPTH : 2);
        chk("al_w0_addr", {24'b0, log_addr[base]}, 32'd0);
        chk("al_w0_data", log_data[base], 32'h00000513);
        chk("al_w1_addr", {24'b0, log_addr[base+1]}, 32'd1);
        chk("al_w1_data", log_data[base+1], 32'h00100593);

        // Misaligned last byte
        do_reset();
        base = wr_n;
        send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b1);
        wait_run();
        chk("mis_nwrites", wr_n - base, FILL ? DEPTH : 1);
        chk("mis_w0_addr", {24'b0, log_addr[base]}, 32'd0);
        chk("mis_w0_data", log_data[base], 32'h00CCBBAA);
        chk("mis_err", {31'b0, err}, 32'd1);
        chk("mis_done", {31'b0, done}, 32'd1);
        chk("mis_count", {23'b0, word_count}, 32'd1);

        // Backpressure and gaps
        do_reset();
        base = wr_n;
        b3[0] = 8'h11; b3[1] = 8'h22; b3[2] = 8'h33; b3[3] = 8'h44;
        b3[4] = 8'h55; b3[5] = 8'h66; b3[6] = 8'h77; b3[7] = 8'h88;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(b3[i], i == 7);
            if (i == 2) begin
                repeat (3) @(negedge clk);
                #1;
                chk("bp_no_partial_write", wr_n - base, 32'd0);
            end
        end
        wait_run();
        chk("bp_nwrites", wr_n - base, FILL ? DEPTH : 2);
        chk("bp_w0_data", log_data[base], 32'h44332211);
        chk("bp_w1_addr", {24'b0, log_addr[base+1]}, 32'd1);
        chk("bp_w1_data", log_data[base+1], 32'h88776655);
        chk("bp_err", {31'b0, err}, 32'd0);

        // Overflow: DEPTH+1 words
        do_reset();
        base = wr_n;
        for (int i = 0; i < 4 * (DEPTH + 1); i++) begin
            send(i[7:0], i == 4 * (DEPTH + 1) - 1);
        end
        chk("ov_suppressed_we", {31'b0, mem_we}, 32'd0);
        wait_run();
        chk("ov_nwrites", wr_n - base, DEPTH);
        chk("ov_w0_data", log_data[base], 32'h03020100);
        chk("ov_w255_addr", {24'b0, log_addr[base+255]}, 32'd255);
        chk("ov_w255_data", log_data[base+255], 32'hFFFEFDFC);
        chk("ov_count", {23'b0, word_count}, 32'd256);
        chk("ov_err", {31'b0, err}, 32'd1);
        chk("ov_done", {31'b0, done}, 32'd1);

        // Reset from RUN drops cpu_start without waiting for a clock
        @(negedge clk);
        #2;
        start = 1'b0;
        #1;
        chk("ar_cpu_start", {31'b0, cpu_start}, 32'd0);
        chk("ar_done", {31'b0, done}, 32'd0);
        chk("ar_err", {31'b0, err}, 32'd0);
        chk("ar_count", {23'b0, word_count}, 32'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);

        // Reset mid-load after 6 bytes
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
        send(8'h04, 1'b0); send(8'h05, 1'b0); send(8'h06, 1'b0);
        #1;
        chk("mid_count_before", {23'b0, word_count}, 32'd1);
        #2;
        start = 1'b0;
        #1;
        chk("mid_count", {23'b0, word_count}, 32'd0);
        chk("mid_ready", {31'b0, byte_ready}, 32'd0);
        chk("mid_we", {31'b0, mem_we}, 32'd0);
        chk("mid_addr", {24'b0, mem_addr}, 32'd0);
        chk("mid_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        base = wr_n;
        send(8'hDE, 1'b0); send(8'hAD, 1'b0); send(8'hBE, 1'b0); send(8'hEF, 1'b1);
        wait_run();
        chk("mid_reload_addr", {24'b0, log_addr[base]}, 32'd0);
        chk("mid_reload_data", log_data[base], 32'hEFBEADDE);
        chk("mid_reload_count", {23'b0, word_count}, 32'd1);

`ifdef IMEM_ZERO_FILL_EN
        // Zero fill after a one-word load
        do_reset();
        base = wr_n;
        send(8'h13, 1'b0); send(8'h05, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b1);
        t = 0;
        while (!(mem_we && mem_addr == 8'd255) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("fill_last_write", {23'b0, mem_we, mem_addr}, {23'b0, 1'b1, 8'd255});
        chk("fill_last_cpu_start", {31'b0, cpu_start}, 32'd0);
        @(negedge clk);
        chk("fill_cpu_start_next", {31'b0, cpu_start}, 32'd1);
        #1;
        chk("fill_nwrites", wr_n - base, DEPTH);
        chk("fill_w1_addr", {24'b0, log_addr[base+1]}, 32'd1);
        chk("fill_w1_data", log_data[base+1], 32'd0);
        chk("fill_w255_data", log_data[base+255], 32'd0);
        chk("fill_count", {23'b0, word_count}, 32'd1);
`else
        t = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that the pipelined CPU fetches from.
- Accepts a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit instruction words.
- Writes each word to sequential instruction-memory word addresses.
- Holds the CPU in reset by driving `cpu_start_o` low until the program is fully loaded, then releases it.

Parameters:
- `DEPTH`, 256, number of 32-bit instruction words in instruction memory.
- `ADDR_W`, 8, word-address width; must equal clog2(`DEPTH`).

Ports:
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `start_i`  in  1  asynchronous active-low reset.
- `byte_valid_i`  in  1  a byte is offered this cycle.
- `byte_data_i`  in  8  offered byte.
- `byte_last_i`  in  1  offered byte is the final byte of the program.
- `byte_ready_o`  out  1  loader accepts the byte this cycle.
- `mem_we_o`  out  1  instruction-memory write strobe, one cycle per word.
- `mem_addr_o`  out  `ADDR_W`  word address of the write.
- `mem_wdata_o`  out  32  instruction word.
- `cpu_start_o`  out  1  start signal to the CPU; low holds the CPU in reset.
- `word_count_o`  out  `ADDR_W`+1  words written so far.
- `done_o`  out  1  load complete; level, stays high until reset.
- `err_o`  out  1  sticky error flag.

Behaviour:
- **Reset (`start_i`=0, async).** State LOAD. Byte lane 0, word pointer 0.
  - Outputs: `byte_ready_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `cpu_start_o`=0, `word_count_o`=0, `done_o`=0, `err_o`=0.
  - `byte_ready_o` rises on the first clock edge after reset deasserts.
- **Handshake.** A byte is transferred when `byte_valid_i` && `byte_ready_o` at a rising edge.
  - `byte_data_i` and `byte_last_i` are sampled only on a transfer.
  - Valid without ready: no effect.
- **Packing.** The byte in lane k goes to bits [8k+7:8k], lanes k=0..3.
  - When lane 3 is transferred, the completed word is presented on the next cycle: `mem_we_o`=1 for exactly one cycle, `mem_addr_o`=word pointer, `mem_wdata_o`=word.
  - The word pointer increments and `word_count_o` increments in that same cycle.
- **Back-to-back.** Latency from lane-3 transfer to write is 1 cycle. `byte_ready_o` stays high during the write cycle; the next word's lane 0 may transfer concurrently.
- **Last byte.** If `byte_last_i` arrives on lane 0, 1 or 2, the unfilled upper lanes are zero-padded and the word is written next cycle as normal. `err_o` is set (misaligned program).
- **States:**
  - LOAD: accept bytes. On a last-byte transfer, go to FLUSH.
  - FLUSH: emit the final word write; `byte_ready_o`=0. Next state is FILL (feature enabled) or RUN.
  - FILL: optional feature only.
  - RUN: `cpu_start_o`=1 and `done_o`=1 from the first RUN cycle; `byte_ready_o`=0; all further bytes ignored.
- **Overflow.** If a word would be written with `word_count_o`==`DEPTH`:
  - Suppress the write (`mem_we_o` stays 0) and set `err_o`.
  - Keep accepting and discarding bytes until last, then go to RUN.
  - `word_count_o` saturates at `DEPTH`.
- **Empty program.** Not representable; the first transferred byte always begins word 0.
- **Reset mid-load.** Asynchronously aborts the load, drops `cpu_start_o` immediately, and clears counters. Memory contents already written are not cleared.
- **Fixed widths.** Word pointer is `ADDR_W` bits; `word_count_o` is `ADDR_W`+1 bits so that `DEPTH` is representable.

Optional Feature:
- Macro: `IMEM_ZERO_FILL_EN`.
- **Defined:** after FLUSH, the loader enters FILL.
  - Writes 32'h0 to every address from `word_count_o` up to `DEPTH`-1, one per cycle with `mem_we_o`=1.
  - `word_count_o` is not incremented by fill writes.
  - Goes to RUN after writing address `DEPTH`-1.
  - If `word_count_o`==`DEPTH`, FILL is skipped.
- **Undefined:** the FILL state does not exist; FLUSH goes directly to RUN and stale memory words are left untouched.

Decomposition:
- **Package `imem_loader_pkg`:**
  - state enum (LOAD, FLUSH, FILL, RUN)
  - `BYTES_PER_WORD`=4
  - word-width constant 32
  - lane-index width 2
- **Sub-module `byte_packer`:**
  - lane counter, 32-bit shift/assembly register, zero-pad on last, word_valid pulse.
  - The top level owns the FSM, address counter, overflow logic and fill.

Test Plan:
- **Aligned load.** Reset, then stream bytes 13,05,00,00, 93,05,10,00 with last on the final byte:
  - writes addr0=32'h00000513 and addr1=32'h00100593;
  - `word_count_o`=2, `err_o`=0;
  - `cpu_start_o` rises 1 cycle after the addr1 write (feature off).
- **Misaligned last.** Stream AA,BB,CC with last:
  - single write addr0=32'h00CCBBAA;
  - `err_o`=1, `done_o`=1.
- **Backpressure and gaps.** Toggle `byte_valid_i` randomly across 8 bytes:
  - exactly 2 writes with correct words;
  - no write occurs without 4 transfers.
- **Overflow.** Send `DEPTH`+1 words (1028 bytes):
  - 256 writes, 257th suppressed;
  - `word_count_o`=256, `err_o`=1, RUN reached.
- **Reset mid-load.** Assert `start_i` low after 6 bytes:
  - all outputs return to reset values asynchronously;
  - a subsequent 4-byte load writes to addr0.
- **`IMEM_ZERO_FILL_EN`.** Load 1 word:
  - 255 zero writes follow at addresses 1..255;
  - `cpu_start_o` rises the cycle after the addr255 write.
